dmac_write_req_gen: RTL and testbench

DMAC_WRITE_REQ_GEN -- requirements
Module: dmac_write_req_gen

---
 rtl/axi4_pkg.sv | 22 ++
 rtl/dmac_outstanding_cnt.sv | 37 +++
 rtl/dmac_write_req_gen.sv | 181 ++++++++++++++++++
 tb/tb_dmac_write_req_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and field widths used by the DMA write path.
// Constants only; no logic, no latency.
package axi4_pkg;

   localparam int BURST_BITS = 2;
   localparam int LEN_BITS   = 8;
   localparam int SIZE_BITS  = 3;
   localparam int RESP_BITS  = 2;

   localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'b00;
   localparam logic [BURST_BITS-1:0] BURST_INCR  = 2'b01;
   localparam logic [BURST_BITS-1:0] BURST_WRAP  = 2'b10;

   localparam logic [RESP_BITS-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_BITS-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [RESP_BITS-1:0] RESP_SLVERR = 2'b10;
   localparam logic [RESP_BITS-1:0] RESP_DECERR = 2'b11;

   localparam int BOUNDARY_4K     = 4096;
   localparam int FIXED_MAX_BEATS = 16;

endpackage

// File: rtl/dmac_outstanding_cnt.sv
// Saturating count of issued-but-unanswered bursts; updates one cycle after inc/dec.
// Never wraps: inc ignored at MAX_OUT, dec ignored at zero; simultaneous inc+dec holds.
module dmac_outstanding_cnt #(
   parameter int MAX_OUT = 8,
   parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [CNT_W-1:0] r_count;
   logic             w_inc;
   logic             w_dec;

   assign w_inc = inc && (r_count != CNT_W'(MAX_OUT));
   assign w_dec = dec && (r_count != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_inc && !w_dec) begin
         r_count <= r_count + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign count = r_count;
   assign full  = (r_count == CNT_W'(MAX_OUT));
   assign empty = (r_count == '0);

endmodule

// File: rtl/dmac_write_req_gen.sv
// Splits a DMA write command into 4 KB-safe AXI bursts and reports completion once all B responses return.
// One SPLIT cycle per burst; stalls on wr_req_ready and on MAX_OUTSTANDING unanswered bursts.
module dmac_write_req_gen
   import axi4_pkg::*;
#(
   parameter int ADDR_WD         = 32,
   parameter int DATA_WD         = 32,
   parameter int MAX_BURST_LEN   = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_in_valid,
   output logic                  cmd_in_ready,
   input  logic [ADDR_WD-1:0]    cmd_in_dst_addr,
   input  logic [BURST_BITS-1:0] cmd_in_burst,
   input  logic [ADDR_WD-1:0]    cmd_in_len,
   input  logic [SIZE_BITS-1:0]  cmd_in_size,
   output logic                  wr_req_valid,
   input  logic                  wr_req_ready,
   output logic [ADDR_WD-1:0]    wr_req_addr,
   output logic [BURST_BITS-1:0] wr_req_burst,
   output logic [LEN_BITS-1:0]   wr_req_len,
   output logic [SIZE_BITS-1:0]  wr_req_size,
   input  logic                  wr_resp_valid,
   input  logic [RESP_BITS-1:0]  wr_resp,
   output logic                  done_valid,
   output logic                  done_err
);

   localparam int STRB_WD = DATA_WD / 8;
   localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_ISSUE, S_DRAIN} state_e;

   state_e                r_state;
   logic [ADDR_WD-1:0]    r_addr;
   logic [BURST_BITS-1:0] r_burst;
   logic [SIZE_BITS-1:0]  r_size;
   logic [ADDR_WD-1:0]    r_rem;
   logic [8:0]            r_beats;
   logic                  r_err;
   logic                  r_cmd_rdy;
   logic                  r_req_vld;
   logic [ADDR_WD-1:0]    r_req_addr;
   logic [BURST_BITS-1:0] r_req_burst;
   logic [LEN_BITS-1:0]   r_req_len;
   logic [SIZE_BITS-1:0]  r_req_size;
   logic                  r_done_vld;
   logic                  r_done_err;

   logic [CNT_W-1:0]      w_count;
   logic                  w_cnt_full;
   logic                  w_cnt_empty;
   logic                  w_hs;
   logic                  w_resp_ok;
   logic                  w_resp_err;
   logic                  w_cmd_bad;
   logic                  w_can_issue;
   logic [12:0]           w_bnd_bytes;
   logic [12:0]           w_bnd_beats;
   logic [12:0]           w_lim;
   logic [8:0]            w_beats;

   assign w_hs        = r_req_vld && wr_req_ready;
   assign w_resp_ok   = wr_resp_valid && (w_count != '0);
   assign w_resp_err  = w_resp_ok && ((wr_resp == RESP_SLVERR) || (wr_resp == RESP_DECERR));
   // A response landing this cycle frees a slot, so a full counter need not cost an extra cycle.
   assign w_can_issue = !w_cnt_full || w_resp_ok;
   assign w_cmd_bad   = !((cmd_in_burst == BURST_INCR) || (cmd_in_burst == BURST_FIXED)) ||
                        ((32'd1 << cmd_in_size) > 32'(STRB_WD));

   assign w_bnd_bytes = 13'(BOUNDARY_4K) - {1'b0, r_addr[11:0]};
   assign w_bnd_beats = w_bnd_bytes >> r_size;

   always_comb begin
      w_lim = (r_burst == BURST_FIXED) ? 13'(FIXED_MAX_BEATS) : 13'(MAX_BURST_LEN);
      // An unaligned start in the last bytes of a page still issues one beat rather than stalling.
      if ((r_burst == BURST_INCR) && (w_bnd_beats < w_lim)) begin
         w_lim = (w_bnd_beats == '0) ? 13'd1 : w_bnd_beats;
      end
      w_beats = (r_rem < ADDR_WD'(w_lim)) ? r_rem[8:0] : w_lim[8:0];
   end

   dmac_outstanding_cnt #(
      .MAX_OUT (MAX_OUTSTANDING)
   ) u_outstanding (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_hs),
      .dec   (wr_resp_valid),
      .count (w_count),
      .full  (w_cnt_full),
      .empty (w_cnt_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_burst     <= '0;
         r_size      <= '0;
         r_rem       <= '0;
         r_beats     <= '0;
         r_err       <= 1'b0;
         r_cmd_rdy   <= 1'b0;
         r_req_vld   <= 1'b0;
         r_req_addr  <= '0;
         r_req_burst <= '0;
         r_req_len   <= '0;
         r_req_size  <= '0;
         r_done_vld  <= 1'b0;
         r_done_err  <= 1'b0;
      end else begin
         r_done_vld <= 1'b0;
         r_done_err <= 1'b0;
         if (w_resp_err) begin
            r_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               r_cmd_rdy <= 1'b1;
               if (r_cmd_rdy && cmd_in_valid) begin
                  r_addr  <= cmd_in_dst_addr;
                  r_burst <= cmd_in_burst;
                  r_size  <= cmd_in_size;
                  r_rem   <= cmd_in_len;
                  r_err   <= 1'b0;
                  if (w_cmd_bad) begin
                     r_done_vld <= 1'b1;
                     r_done_err <= 1'b1;
                  end else begin
                     r_cmd_rdy <= 1'b0;
                     r_state   <= (cmd_in_len == '0) ? S_DRAIN : S_SPLIT;
                  end
               end
            end
            S_SPLIT: begin
               if (w_can_issue) begin
                  r_beats     <= w_beats;
                  r_req_vld   <= 1'b1;
                  r_req_addr  <= r_addr;
                  r_req_burst <= r_burst;
                  r_req_len   <= LEN_BITS'(w_beats - 9'd1);
                  r_req_size  <= r_size;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (wr_req_ready) begin
                  r_req_vld <= 1'b0;
                  r_rem     <= r_rem - ADDR_WD'(r_beats);
                  if (r_burst == BURST_INCR) begin
                     r_addr <= r_addr + (ADDR_WD'(r_beats) << r_size);
                  end
                  r_state <= (r_rem == ADDR_WD'(r_beats)) ? S_DRAIN : S_SPLIT;
               end
            end
            S_DRAIN: begin
               if (w_cnt_empty) begin
                  r_done_vld <= 1'b1;
                  r_done_err <= r_err;
                  r_cmd_rdy  <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_in_ready = r_cmd_rdy;
   assign wr_req_valid = r_req_vld;
   assign wr_req_addr  = r_req_addr;
   assign wr_req_burst = r_req_burst;
   assign wr_req_len   = r_req_len;
   assign wr_req_size  = r_req_size;
   assign done_valid   = r_done_vld;
   assign done_err     = r_done_err;

endmodule

// File: tb/tb_dmac_write_req_gen.sv
// Directed bench for dmac_write_req_gen: command table with expected burst lists, plus
// hand sequences for outstanding-limit stall and mid-issue reset.
module tb_dmac_write_req_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_in_valid;
   logic        cmd_in_ready;
   logic [31:0] cmd_in_dst_addr;
   logic [1:0]  cmd_in_burst;
   logic [31:0] cmd_in_len;
   logic [2:0]  cmd_in_size;
   logic        wr_req_valid;
   logic        wr_req_ready;
   logic [31:0] wr_req_addr;
   logic [1:0]  wr_req_burst;
   logic [7:0]  wr_req_len;
   logic [2:0]  wr_req_size;
   logic        wr_resp_valid;
   logic [1:0]  wr_resp;
   logic        done_valid;
   logic        done_err;

   always #5 clk = ~clk;

   dmac_write_req_gen #(
      .ADDR_WD         (32),
      .DATA_WD         (32),
      .MAX_BURST_LEN   (16),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_in_valid    (cmd_in_valid),
      .cmd_in_ready    (cmd_in_ready),
      .cmd_in_dst_addr (cmd_in_dst_addr),
      .cmd_in_burst    (cmd_in_burst),
      .cmd_in_len      (cmd_in_len),
      .cmd_in_size     (cmd_in_size),
      .wr_req_valid    (wr_req_valid),
      .wr_req_ready    (wr_req_ready),
      .wr_req_addr     (wr_req_addr),
      .wr_req_burst    (wr_req_burst),
      .wr_req_len      (wr_req_len),
      .wr_req_size     (wr_req_size),
      .wr_resp_valid   (wr_resp_valid),
      .wr_resp         (wr_resp),
      .done_valid      (done_valid),
      .done_err        (done_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  burst;
      logic [31:0] len;
      logic [2:0]  size;
      int          err_idx;
      int          nb;
      int          first;
      logic        exp_err;
      int          lat;
   } vec_t;

   vec_t        vt[10];
   logic [31:0] eb_addr[12];
   logic [7:0]  eb_len[12];

   int          checks = 0;
   int          errors = 0;

   int          got_n;
   logic        got_done;
   logic        got_err;
   int          got_lat;
   logic [31:0] got_addr[16];
   logic [7:0]  got_len[16];
   logic [1:0]  got_burst[16];
   logic [2:0]  got_size[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [1:0] b,
                           input logic [31:0] l, input logic [2:0] s);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      cmd_in_valid    = 1'b1;
      cmd_in_dst_addr = a;
      cmd_in_burst    = b;
      cmd_in_len      = l;
      cmd_in_size     = s;
      for (int c = 0; c < 50; c++) begin
         if (cmd_in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 cmd_in_valid = 1'b0;
      chk("cmd_accept", 32'(ok), 32'd1);
   endtask

   // Accepts every burst and answers each one in issue order on the following cycle.
   task automatic collect(input int pend0, input int err_idx);
      int pend;
      int ridx;
      pend     = pend0;
      ridx     = 0;
      got_n    = 0;
      got_done = 1'b0;
      got_err  = 1'b0;
      got_lat  = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (done_valid) begin
            got_done = 1'b1;
            got_err  = done_err;
            got_lat  = c;
            break;
         end
         wr_resp_valid = 1'b0;
         wr_resp       = 2'b00;
         if (pend > 0) begin
            wr_resp_valid = 1'b1;
            wr_resp       = (ridx == err_idx) ? 2'b10 : 2'b00;
            ridx++;
            pend--;
         end
         if (wr_req_valid && wr_req_ready) begin
            if (got_n < 16) begin
               got_addr[got_n]  = wr_req_addr;
               got_len[got_n]   = wr_req_len;
               got_burst[got_n] = wr_req_burst;
               got_size[got_n]  = wr_req_size;
            end
            got_n++;
            pend++;
         end
      end
      wr_resp_valid = 1'b0;
      chk("done_seen", 32'(got_done), 32'd1);
   endtask

   initial begin
      int nhs;
      int ndone;

      vt[0] = '{addr:32'h0000_1000, burst:2'b01, len:40, size:3'd2, err_idx:-1, nb:3, first:0,  exp_err:1'b0, lat:0};
      vt[1] = '{addr:32'h0000_0FF8, burst:2'b01, len:8,  size:3'd2, err_idx:-1, nb:2, first:3,  exp_err:1'b0, lat:0};
      vt[2] = '{addr:32'h0000_0020, burst:2'b00, len:20, size:3'd2, err_idx:-1, nb:2, first:5,  exp_err:1'b0, lat:0};
      vt[3] = '{addr:32'h0000_0300, burst:2'b01, len:0,  size:3'd2, err_idx:-1, nb:0, first:0,  exp_err:1'b0, lat:2};
      vt[4] = '{addr:32'h0000_0040, burst:2'b10, len:4,  size:3'd2, err_idx:-1, nb:0, first:0,  exp_err:1'b1, lat:1};
      vt[5] = '{addr:32'h0000_0040, burst:2'b01, len:4,  size:3'd3, err_idx:-1, nb:0, first:0,  exp_err:1'b1, lat:1};
      vt[6] = '{addr:32'h0000_0000, burst:2'b01, len:20, size:3'd2, err_idx:0,  nb:2, first:7,  exp_err:1'b1, lat:0};
      vt[7] = '{addr:32'h0000_2000, burst:2'b01, len:5,  size:3'd0, err_idx:-1, nb:1, first:9,  exp_err:1'b0, lat:0};
      vt[8] = '{addr:32'hFFFF_FFF0, burst:2'b01, len:8,  size:3'd2, err_idx:-1, nb:2, first:10, exp_err:1'b0, lat:0};
      vt[9] = '{addr:32'h0000_0040, burst:2'b11, len:4,  size:3'd2, err_idx:-1, nb:0, first:0,  exp_err:1'b1, lat:1};
      eb_addr = '{32'h1000, 32'h1040, 32'h1080, 32'h0FF8, 32'h1000, 32'h20, 32'h20,
                  32'h0, 32'h40, 32'h2000, 32'hFFFF_FFF0, 32'h0};
      eb_len  = '{8'd15, 8'd15, 8'd7, 8'd1, 8'd5, 8'd15, 8'd3, 8'd15, 8'd3, 8'd4, 8'd3, 8'd3};

      rst             = 1'b0;
      cmd_in_valid    = 1'b0;
      cmd_in_dst_addr = '0;
      cmd_in_burst    = '0;
      cmd_in_len      = '0;
      cmd_in_size     = '0;
      wr_req_ready    = 1'b1;
      wr_resp_valid   = 1'b0;
      wr_resp         = '0;

      #1;
      chk("rst cmd_in_ready", 32'(cmd_in_ready), 32'd0);
      chk("rst wr_req_valid", 32'(wr_req_valid), 32'd0);
      chk("rst done_valid",   32'(done_valid),   32'd0);
      chk("rst wr_req_addr",  wr_req_addr,       32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready after rst", 32'(cmd_in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         send_cmd(vt[i].addr, vt[i].burst, vt[i].len, vt[i].size);
         collect(0, vt[i].err_idx);
         chk($sformatf("v%0d nbursts", i), 32'(got_n), 32'(vt[i].nb));
         for (int k = 0; k < vt[i].nb && k < got_n; k++) begin
            chk($sformatf("v%0d b%0d addr", i, k),  got_addr[k], eb_addr[vt[i].first + k]);
            chk($sformatf("v%0d b%0d len", i, k),   32'(got_len[k]), 32'(eb_len[vt[i].first + k]));
            chk($sformatf("v%0d b%0d burst", i, k), 32'(got_burst[k]), 32'(vt[i].burst));
            chk($sformatf("v%0d b%0d size", i, k),  32'(got_size[k]), 32'(vt[i].size));
         end
         chk($sformatf("v%0d done_err", i), 32'(got_err), 32'(vt[i].exp_err));
         if (vt[i].lat != 0) begin
            chk($sformatf("v%0d done_lat", i), 32'(got_lat), 32'(vt[i].lat));
         end
         @(negedge clk);
         chk($sformatf("v%0d done_pulse_width", i), 32'(done_valid), 32'd0);
      end

      // Outstanding limit of 2 with responses withheld.
      send_cmd(32'h0, 2'b01, 32'd64, 3'd2);
      nhs = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr_req_valid && wr_req_ready) nhs++;
      end
      chk("outst withheld reqs", 32'(nhs), 32'd2);
      @(negedge clk);
      chk("outst stalled", 32'(wr_req_valid), 32'd0);
      wr_resp_valid = 1'b1;
      wr_resp       = 2'b00;
      @(negedge clk);
      wr_resp_valid = 1'b0;
      chk("outst third issue", 32'(wr_req_valid), 32'd1);
      chk("outst third addr",  wr_req_addr, 32'h80);
      collect(2, -1);
      chk("outst remaining reqs", 32'(got_n), 32'd1);
      chk("outst done_err",       32'(got_err), 32'd0);

      // Reset while a burst request is held by wr_req_ready low.
      wr_req_ready = 1'b0;
      send_cmd(32'h100, 2'b01, 32'd4, 3'd2);
      nhs = 0;
      for (int c = 0; c < 20 && nhs == 0; c++) begin
         @(negedge clk);
         if (wr_req_valid) nhs = 1;
      end
      chk("stall req seen", 32'(nhs), 32'd1);
      @(negedge clk);
      chk("stall valid held", 32'(wr_req_valid), 32'd1);
      chk("stall addr held",  wr_req_addr, 32'h100);
      chk("stall len",        32'(wr_req_len), 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("midrst wr_req_valid", 32'(wr_req_valid), 32'd0);
      chk("midrst wr_req_len",   32'(wr_req_len),   32'd0);
      chk("midrst cmd_in_ready", 32'(cmd_in_ready), 32'd0);
      chk("midrst done_valid",   32'(done_valid),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst          = 1'b1;
      wr_req_ready = 1'b1;
      @(negedge clk);
      chk("midrst ready after release", 32'(cmd_in_ready), 32'd1);
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done_valid || wr_req_valid) ndone++;
      end
      chk("midrst no done/req", 32'(ndone), 32'd0);

      send_cmd(32'h1000, 2'b01, 32'd40, 3'd2);
      collect(0, -1);
      chk("post-rst nbursts", 32'(got_n), 32'd3);
      chk("post-rst done_err", 32'(got_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
